dp_share_arbiter: RTL and testbench
===================================

// Module: dp_share_arbiter
//
// PURPOSE
// Round-robin arbiter that time-shares one fixed-latency datapath unit (e.g. the
// inverting submodule) between NumReq requesters. Accepts one request at a time
// via valid/ready, drives the operand to the unit, waits DpLatency cycles, then
// returns the result to the granted requester via valid/ready. Sits between the
// requesting agents and the single shared datapath instance in the top level.
//
// PARAMETERS
// NumReq     default 4  number of requesters, >= 1
// DataWidth  default 8  operand/result width in bits, >= 1
// DpLatency  default 1  fixed unit latency in cycles, dp_data_o to dp_data_i, >= 1
//
// PORTS
// clk_i        in   1                  clock, all state on rising edge
// rst_ni       in   1                  asynchronous reset, active low
// req_valid_i  in   NumReq             per-requester request valid
// req_data_i   in   NumReq*DataWidth   per-requester operand, [i*DataWidth +: DataWidth]
// req_ready_o  out  NumReq             one-hot grant/accept strobe
// dp_valid_o   out  1                  operand on dp_data_o is live (state BUSY)
// dp_data_o    out  DataWidth          registered operand to shared unit
// dp_data_i    in   DataWidth          result from shared unit
// rsp_valid_o  out  NumReq             one-hot response valid to owner
// rsp_data_o   out  DataWidth          registered result, shared by all requesters
// rsp_ready_i  in   NumReq             per-requester response ready
//
// BEHAVIOUR
// - Reset: state=IDLE, rr_ptr=0, owner=0, cnt=0, dp_data_o=0, rsp_data_o=0;
//   req_ready_o, dp_valid_o, rsp_valid_o all 0.
// - States: IDLE -> BUSY -> RESP -> IDLE.
// - IDLE: grant = first i with req_valid_i[i], searching rr_ptr, rr_ptr+1, ...
//   mod NumReq. req_ready_o[grant]=1 combinationally, only in IDLE, only if any valid.
//   On accept: dp_data_o <= req_data_i[grant], owner <= grant, cnt <= DpLatency-1,
//   -> BUSY. No valid: stay IDLE, req_ready_o=0.
// - BUSY: dp_valid_o=1, dp_data_o held. cnt==0: rsp_data_o <= dp_data_i, -> RESP;
//   else cnt <= cnt-1. All req_ready_o=0.
// - RESP: rsp_valid_o[owner]=1, rsp_data_o held. On rsp_ready_i[owner]:
//   rr_ptr <= (owner==NumReq-1) ? 0 : owner+1, -> IDLE. rsp_ready_i of
//   non-owners ignored. All req_ready_o=0.
// - Latency: accept at cycle T, rsp_valid_o high at T+DpLatency+1. Minimum
//   period per transaction DpLatency+2 cycles (no overlap, no bypass).
// - Requester may drop req_valid_i after accept; transaction still completes.
// - Requests arriving in BUSY/RESP wait; round-robin guarantees each active
//   requester is served within NumReq transactions.
// - NumReq==1: rr_ptr/owner width max(1,$clog2(NumReq)), always 0.
// - Async reset mid-transaction aborts it; no response produced.
//
// CONFIGURATION
// DP_SHARE_ARBITER_PERF_EN defined: extra port busy_cycles_o out 32, counts
//   cycles with state != IDLE, reset 0, saturates at 32'hFFFF_FFFF.
// Not defined: port and counter absent; all other behaviour identical.
//
// TESTING (NumReq=4, DataWidth=8, DpLatency=1, unit = bitwise invert)
// - Reset: hold rst_ni=0 with all req_valid_i=1 -> all outputs 0, no accept.
// - Single: req 2 valid, data 8'hA5, rsp_ready=1 -> req_ready_o=4'b0100 at T,
//   dp_data_o=8'hA5 at T+1, rsp_valid_o=4'b0100, rsp_data_o=8'h5A at T+2.
// - Fairness: all 4 valid continuously, rsp_ready=4'hF -> grants 0,1,2,3,0 in
//   order, one every 3 cycles.
// - Backpressure: owner 1 rsp_ready=0 for 5 cycles -> rsp_valid_o=4'b0010 and
//   rsp_data_o stable 5 cycles; no new accept until handshake.
// - Wrap: rr_ptr=3 after owner 2, only req 0 valid -> req 0 granted.
// - Abort: rst_ni low in BUSY -> outputs 0; after release, pending req 3
//   granted first (rr_ptr=0 search finds 3), result correct.
// - PERF_EN: 2 back-to-back single transactions, DpLatency=1 -> busy_cycles_o=4.

Source files
------------

// File: rtl/dp_share_arbiter_if.sv
// dp_share_arbiter_if: requester and shared-unit signals of dp_share_arbiter.
// Rev 1.0 - initial release.
`default_nettype none

interface dp_share_arbiter_if #(
  parameter int NumReq    = 4,
  parameter int DataWidth = 8
);
  logic [NumReq-1:0]           req_valid_i;
  logic [NumReq*DataWidth-1:0] req_data_i;
  logic [NumReq-1:0]           req_ready_o;
  logic                        dp_valid_o;
  logic [DataWidth-1:0]        dp_data_o;
  logic [DataWidth-1:0]        dp_data_i;
  logic [NumReq-1:0]           rsp_valid_o;
  logic [DataWidth-1:0]        rsp_data_o;
  logic [NumReq-1:0]           rsp_ready_i;

  // Arbiter side
  modport slave (
    input  req_valid_i, req_data_i, dp_data_i, rsp_ready_i,
    output req_ready_o, dp_valid_o, dp_data_o, rsp_valid_o, rsp_data_o
  );

  // Requester / datapath side
  modport master (
    output req_valid_i, req_data_i, dp_data_i, rsp_ready_i,
    input  req_ready_o, dp_valid_o, dp_data_o, rsp_valid_o, rsp_data_o
  );
endinterface

`default_nettype wire

// File: rtl/dp_share_arbiter.sv
// ============================================================================
// dp_share_arbiter: round-robin sharing of one fixed-latency datapath unit.
// Optional macro DP_SHARE_ARBITER_PERF_EN adds busy_cycles_o (non-IDLE cycles).
// Rev 1.0 - initial release.
// ============================================================================
`default_nettype none

module dp_share_arbiter #(
  parameter int NumReq    = 4,
  parameter int DataWidth = 8,
  parameter int DpLatency = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  dp_share_arbiter_if.slave      bus
`ifdef DP_SHARE_ARBITER_PERF_EN
  ,
  output logic [31:0]            busy_cycles_o
`endif
);

  localparam int PTR_W = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int CNT_W = (DpLatency > 1) ? $clog2(DpLatency) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DpLatency - 1);
  localparam logic [PTR_W-1:0] LAST_REQ = PTR_W'(NumReq - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]           state;
  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     owner;
  logic [CNT_W-1:0]     cnt;
  logic [DataWidth-1:0] dp_data;
  logic [DataWidth-1:0] rsp_data;

  logic                 any_valid;
  logic [PTR_W-1:0]     grant;
  logic [DataWidth-1:0] grant_data;
  logic                 owner_ready;
  logic [NumReq-1:0]    grant_oh;
  logic [NumReq-1:0]    owner_oh;
  int                   idx;

  // Walk from farthest to nearest so the first valid after rr_ptr wins.
  always_comb begin
    any_valid = |bus.req_valid_i;
    grant     = '0;
    idx       = 0;
    for (int k = NumReq - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NumReq) idx = idx - NumReq;
      if (bus.req_valid_i[idx]) grant = PTR_W'(idx);
    end
  end

  always_comb begin
    grant_data  = '0;
    owner_ready = 1'b0;
    grant_oh    = '0;
    owner_oh    = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (PTR_W'(i) == grant) begin
        grant_data  = bus.req_data_i[i*DataWidth +: DataWidth];
        grant_oh[i] = 1'b1;
      end
      if (PTR_W'(i) == owner) begin
        owner_ready = bus.rsp_ready_i[i];
        owner_oh[i] = 1'b1;
      end
    end
  end

  // Accept strobe is masked during reset so a held request is never acknowledged.
  assign bus.req_ready_o = (rst_ni && state == IDLE && any_valid) ? grant_oh : '0;
  assign bus.dp_valid_o  = (state == BUSY);
  assign bus.dp_data_o   = dp_data;
  assign bus.rsp_valid_o = (state == RESP) ? owner_oh : '0;
  assign bus.rsp_data_o  = rsp_data;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      cnt      <= '0;
      dp_data  <= '0;
      rsp_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            dp_data <= grant_data;
            owner   <= grant;
            cnt     <= CNT_INIT;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            rsp_data <= bus.dp_data_i;
            state    <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (owner_ready) begin
            rr_ptr <= (owner == LAST_REQ) ? '0 : owner + 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DP_SHARE_ARBITER_PERF_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_cycles_o <= '0;
    end else if (state != IDLE && busy_cycles_o != 32'hFFFF_FFFF) begin
      busy_cycles_o <= busy_cycles_o + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_dp_share_arbiter.sv
// tb_dp_share_arbiter: directed vector table plus hand-written multi-cycle sequences.
// Rev 1.0 - initial release.
`default_nettype none

module tb_dp_share_arbiter;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  int   n_vec  = 0;
  int   n_err  = 0;

  dp_share_arbiter_if #(.NumReq(4), .DataWidth(8)) bus ();

`ifdef DP_SHARE_ARBITER_PERF_EN
  logic [31:0] busy_cycles_o;
`endif

  dp_share_arbiter #(.NumReq(4), .DataWidth(8), .DpLatency(1)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
`ifdef DP_SHARE_ARBITER_PERF_EN
    ,
    .busy_cycles_o (busy_cycles_o)
`endif
  );

  // Shared unit: bitwise invert, one cycle of latency comes from the arbiter's RESP capture
  assign bus.dp_data_i = ~bus.dp_data_o;

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  rdy;
    logic [3:0]  e_req_ready;
    logic        e_dp_valid;
    logic [7:0]  e_dp_data;
    logic [3:0]  e_rsp_valid;
    logic [7:0]  e_rsp_data;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic [31:0] d, input logic [3:0] r);
    bus.req_valid_i = v;
    bus.req_data_i  = d;
    bus.rsp_ready_i = r;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    drive(4'h0, 32'h0, 4'hF);
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    logic [3:0] e_oh;
    logic [7:0] e_d;
    int         g;

    vecs[0] = '{4'b0100, 32'h00A5_0000, 4'hF, 4'b0100, 1'b0, 8'h00, 4'b0000, 8'h00};
    vecs[1] = '{4'b0000, 32'h0000_0000, 4'hF, 4'b0000, 1'b1, 8'hA5, 4'b0000, 8'h00};
    vecs[2] = '{4'b0000, 32'h0000_0000, 4'hF, 4'b0000, 1'b0, 8'hA5, 4'b0100, 8'h5A};
    vecs[3] = '{4'b0001, 32'h0000_003C, 4'hF, 4'b0001, 1'b0, 8'hA5, 4'b0000, 8'h5A};
    vecs[4] = '{4'b0001, 32'h0000_003C, 4'hF, 4'b0000, 1'b1, 8'h3C, 4'b0000, 8'h5A};
    vecs[5] = '{4'b0001, 32'h0000_003C, 4'h0, 4'b0000, 1'b0, 8'h3C, 4'b0001, 8'hC3};
    vecs[6] = '{4'b0001, 32'h0000_003C, 4'hE, 4'b0000, 1'b0, 8'h3C, 4'b0001, 8'hC3};
    vecs[7] = '{4'b0001, 32'h0000_003C, 4'h1, 4'b0000, 1'b0, 8'h3C, 4'b0001, 8'hC3};
    vecs[8] = '{4'b0000, 32'h0000_0000, 4'hF, 4'b0000, 1'b0, 8'h3C, 4'b0000, 8'hC3};

    // Reset held with every requester valid
    drive(4'hF, 32'h4433_2211, 4'hF);
    repeat (3) @(negedge clk_i);
    chk("rst_req_ready", 32'(bus.req_ready_o), 32'h0);
    chk("rst_dp_valid",  32'(bus.dp_valid_o),  32'h0);
    chk("rst_dp_data",   32'(bus.dp_data_o),   32'h0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'h0);
    chk("rst_rsp_data",  32'(bus.rsp_data_o),  32'h0);

    // Single transaction, wrap to req 0, owner backpressure with non-owner ready ignored
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].valid, vecs[i].data, vecs[i].rdy);
      @(negedge clk_i);
      chk($sformatf("v%0d_req_ready", i), 32'(bus.req_ready_o), 32'(vecs[i].e_req_ready));
      chk($sformatf("v%0d_dp_valid", i),  32'(bus.dp_valid_o),  32'(vecs[i].e_dp_valid));
      chk($sformatf("v%0d_dp_data", i),   32'(bus.dp_data_o),   32'(vecs[i].e_dp_data));
      chk($sformatf("v%0d_rsp_valid", i), 32'(bus.rsp_valid_o), 32'(vecs[i].e_rsp_valid));
      chk($sformatf("v%0d_rsp_data", i),  32'(bus.rsp_data_o),  32'(vecs[i].e_rsp_data));
      next_cycle();
    end

    // Fairness: all valid, grants 0,1,2,3,0 every third cycle
    do_reset();
    drive(4'hF, 32'h4433_2211, 4'hF);
    for (int n = 0; n < 15; n++) begin
      g    = (n / 3) % 4;
      e_oh = 4'(1 << g);
      e_d  = ~(8'h11 * 8'(g + 1));
      @(negedge clk_i);
      chk($sformatf("fair%0d_req_ready", n), 32'(bus.req_ready_o), (n % 3 == 0) ? 32'(e_oh) : 32'h0);
      if (n % 3 == 2) begin
        chk($sformatf("fair%0d_rsp_valid", n), 32'(bus.rsp_valid_o), 32'(e_oh));
        chk($sformatf("fair%0d_rsp_data", n),  32'(bus.rsp_data_o),  32'(e_d));
      end
      next_cycle();
    end

    // Backpressure on owner 1 for 5 cycles while others keep requesting
    do_reset();
    drive(4'b0010, 32'h0000_7700, 4'h0);
    @(negedge clk_i);
    chk("bp_accept", 32'(bus.req_ready_o), 32'h2);
    next_cycle();
    drive(4'hF, 32'h4433_2211, 4'h0);
    @(negedge clk_i);
    chk("bp_dp_data", 32'(bus.dp_data_o), 32'h77);
    next_cycle();
    for (int n = 0; n < 5; n++) begin
      @(negedge clk_i);
      chk($sformatf("bp%0d_rsp_valid", n), 32'(bus.rsp_valid_o), 32'h2);
      chk($sformatf("bp%0d_rsp_data", n),  32'(bus.rsp_data_o),  32'h88);
      chk($sformatf("bp%0d_req_ready", n), 32'(bus.req_ready_o), 32'h0);
      next_cycle();
    end
    bus.rsp_ready_i = 4'b0010;
    @(negedge clk_i);
    chk("bp_hs_rsp_valid", 32'(bus.rsp_valid_o), 32'h2);
    next_cycle();
    @(negedge clk_i);
    chk("bp_next_grant", 32'(bus.req_ready_o), 32'h4);
    next_cycle();

    // Abort: reset during BUSY, then pending req 3 served first
    do_reset();
    drive(4'b0001, 32'h0000_0012, 4'hF);
    @(negedge clk_i);
    chk("ab_accept", 32'(bus.req_ready_o), 32'h1);
    next_cycle();
    drive(4'b1000, 32'hF000_0000, 4'hF);
    @(negedge clk_i);
    chk("ab_busy", 32'(bus.dp_valid_o), 32'h1);
    #2 rst_ni = 1'b0;
    #1;
    chk("ab_dp_valid",  32'(bus.dp_valid_o),  32'h0);
    chk("ab_dp_data",   32'(bus.dp_data_o),   32'h0);
    chk("ab_req_ready", 32'(bus.req_ready_o), 32'h0);
    chk("ab_rsp_valid", 32'(bus.rsp_valid_o), 32'h0);
    next_cycle();
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("ab_grant3", 32'(bus.req_ready_o), 32'h8);
    next_cycle();
    drive(4'b0000, 32'h0, 4'hF);
    @(negedge clk_i);
    chk("ab_dp_f0", 32'(bus.dp_data_o), 32'hF0);
    next_cycle();
    @(negedge clk_i);
    chk("ab_rsp_valid3", 32'(bus.rsp_valid_o), 32'h8);
    chk("ab_rsp_data",   32'(bus.rsp_data_o),  32'h0F);
    next_cycle();

`ifdef DP_SHARE_ARBITER_PERF_EN
    // Two back-to-back transactions: BUSY+RESP each
    do_reset();
    drive(4'b0001, 32'h0000_0001, 4'hF);
    repeat (6) next_cycle();
    drive(4'b0000, 32'h0, 4'hF);
    @(negedge clk_i);
    chk("perf_busy_cycles", busy_cycles_o, 32'd4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
